biquad_cascade_seq: RTL and testbench
=====================================

BIQUAD_CASCADE_SEQ -- requirements
Module: biquad_cascade_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- W, 24, sample width in bits, signed two's complement.
- F, 14, fractional bits of the 16-bit signed coefficients (Q1.14).
- SECTIONS, 2, number of cascaded biquad sections, legal range 1..8.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- in_valid, in, 1, input sample offered.
- in_ready, out, 1, block idle and able to accept a sample.
- in_data, in, W, input sample x.
- out_valid, out, 1, one-cycle result strobe.
- out_data, out, W, filtered sample y of the last section.
- coef_we, in, 1, coefficient write strobe.
- coef_addr, in, 6, coefficient address = section*5 + index, where index 0..4 = b0, b1, b2, a1, a2.
- coef_data, in, 16, signed coefficient.
- clr_state, in, 1, clear all delay lines.
- sat_flag, out, 1, sticky saturation indicator.

Function
REQ-003 The FSM SHALL have the states IDLE, MAC, UPDATE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-004 An edge with in_valid=1 and in_ready=1 SHALL capture in_data as x, set section=0 and k=0, clear the accumulator, and go to MAC.
REQ-005 MAC SHALL perform one signed multiply-accumulate per cycle for k=0..4, in this order: b0*x, b1*x1, b2*x2, a1*y1, a2*y2. All terms are added; the feedback sign is carried in the stored a1/a2 values.
REQ-006 Each product SHALL be (W+16) bits; the accumulator SHALL be W+19 bits, so no internal overflow occurs.
REQ-007 UPDATE SHALL form q = acc >>> F (arithmetic shift, truncation) and reduce it to W bits per REQ-016.
- It SHALL then shift that section's delay lines: x2<=x1, x1<=x, y2<=y1, y1<=q.
- q SHALL become x for the next section.
REQ-008 After the UPDATE of the last section the FSM SHALL enter DONE, load out_data with q, and assert out_valid for exactly one cycle; DONE SHALL then return to IDLE.
REQ-009 Latency SHALL be as follows:
- out_valid rises 6*SECTIONS cycles after the accepting edge.
- Throughput is one sample per 6*SECTIONS+1 cycles.
- out_data SHALL hold its value until the next DONE.
REQ-010 in_valid while busy SHALL be ignored; no sample queueing.
REQ-011 coef_we SHALL write a coefficient only in IDLE with coef_addr < 5*SECTIONS.
- Writes while busy SHALL be dropped.
- Writes to an out-of-range address SHALL be dropped.
REQ-012 A coefficient write and a sample acceptance in the same IDLE cycle SHALL both take effect; the sample SHALL use the new coefficient.
REQ-013 clr_state in IDLE SHALL zero all x1, x2, y1, y2 registers; in other states clr_state SHALL be ignored. If clr_state and in_valid occur together in IDLE, the clear SHALL apply first and the sample SHALL be accepted.

Reset
REQ-014 reset SHALL asynchronously force the following:
- State IDLE, in_ready=1, out_valid=0, out_data=0, sat_flag=0, accumulator=0.
- All delay lines = 0.
- Every section b0=16384 (1.0) and all other coefficients = 0, giving unity passthrough.
REQ-015 reset asserted mid-operation SHALL abandon the sample with no out_valid.

Configuration
REQ-016 With the macro BIQUAD_SAT_EN defined:
- q outside [-2^(W-1), 2^(W-1)-1] SHALL clamp to the nearest bound.
- Any clamp SHALL set sat_flag, which stays set until reset.
Without BIQUAD_SAT_EN:
- q SHALL be truncated to its low W bits (wrap-around).
- sat_flag SHALL be constant 0.

Verification
REQ-017 Bench scenarios (W=24, F=14, SECTIONS=2):
- Reset, then x=1000 -> out_valid 12 cycles after acceptance, out_data=1000, in_ready low for 13 cycles.
- Section0 b0=b1=b2=8192, section1 default; inputs 16384, 0, 0, 0 -> outputs 8192, 8192, 8192, 0.
- Section0 a1=8192, section1 default; impulse 16384 then zeros -> 16384, 8192, 4096, 2048, 1024.
- Section0 b0=32767; x=8388607 -> with BIQUAD_SAT_EN: out_data=8388607 and sat_flag=1; without it: wrapped negative value and sat_flag=0.
- reset pulsed during MAC of section1 -> no out_valid; after release in_ready=1 and a subsequent x=5 returns 5.
- coef_we to addr 0 with data 0 while busy -> ignored, next output equals unity passthrough; addr 10 written in IDLE -> ignored.

Source files
------------

// File: rtl/biquad_cascade_seq.sv
// Time-multiplexed cascade of Direct-Form-I biquads: one shared multiplier, five MACs plus one
// update cycle per section. Define BIQUAD_SAT_EN to clamp section outputs and enable sat_flag.
module biquad_cascade_seq #(
    parameter int W        = 24,
    parameter int F        = 14,
    parameter int SECTIONS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_data,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    input  logic                coef_we,
    input  logic [5:0]          coef_addr,
    input  logic [15:0]         coef_data,
    input  logic                clr_state,
    output logic                sat_flag
);
    localparam int PW   = W + 16;
    localparam int ACCW = W + 19;
    localparam int SW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int NS   = 2 ** SW;
    localparam logic [5:0] NCOEF = 6'(5 * SECTIONS);

    typedef enum logic [1:0] {IDLE, MAC, UPDATE, DONE} state_t;

    state_t                 state, state_nx;
    logic [SW-1:0]          sec;
    logic [2:0]             k;
    logic signed [W-1:0]    x_cur;
    logic signed [ACCW-1:0] acc;
    logic signed [15:0]     coef [NS][5];
    logic signed [W-1:0]    x1 [NS];
    logic signed [W-1:0]    x2 [NS];
    logic signed [W-1:0]    y1 [NS];
    logic signed [W-1:0]    y2 [NS];
    logic signed [W-1:0]    mul_a;
    logic signed [15:0]     mul_b;
    logic signed [PW-1:0]   prod;
    logic signed [W-1:0]    q;
    logic                   q_clip;
    logic                   last_sec;
    logic                   out_valid_r;
    logic [W-1:0]           out_data_r;
    logic                   sat_flag_r;

    assign in_ready  = (state == IDLE);
    assign last_sec  = (sec == SW'(SECTIONS - 1));
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign sat_flag  = sat_flag_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: five MAC cycles then one UPDATE per section
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = MAC;    else state_nx = IDLE;
            MAC:     if (k == 3'd4) state_nx = UPDATE; else state_nx = MAC;
            UPDATE:  if (last_sec) state_nx = DONE;   else state_nx = MAC;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shared multiplier operand select, ordered b0*x, b1*x1, b2*x2, a1*y1, a2*y2
    always_comb begin
        mul_a = x_cur;
        mul_b = 16'sd0;
        case (k)
            3'd0:    begin mul_a = x_cur;   mul_b = coef[sec][0]; end
            3'd1:    begin mul_a = x1[sec]; mul_b = coef[sec][1]; end
            3'd2:    begin mul_a = x2[sec]; mul_b = coef[sec][2]; end
            3'd3:    begin mul_a = y1[sec]; mul_b = coef[sec][3]; end
            3'd4:    begin mul_a = y2[sec]; mul_b = coef[sec][4]; end
            default: begin mul_a = x_cur;   mul_b = 16'sd0;       end
        endcase
    end

    assign prod = mul_a * mul_b;

`ifdef BIQUAD_SAT_EN
    logic signed [ACCW-1:0] q_full;
    assign q_full = acc >>> F;

    // Clamp when the bits above the W-bit sign are not a pure sign extension
    always_comb begin
        q      = q_full[W-1:0];
        q_clip = 1'b0;
        if ((&q_full[ACCW-1:W-1]) || !(|q_full[ACCW-1:W-1])) begin
            q = q_full[W-1:0];
        end else begin
            q_clip = 1'b1;
            q      = q_full[ACCW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    // Wrap-around: keep the low W bits of acc >>> F
    always_comb begin
        q      = acc[F+W-1:F];
        q_clip = 1'b0;
    end
`endif

    // Datapath: coefficient RAM, delay lines, accumulator and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec         <= '0;
            k           <= 3'd0;
            x_cur       <= '0;
            acc         <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            sat_flag_r  <= 1'b0;
            for (int s = 0; s < NS; s++) begin
                coef[s][0] <= 16'sd16384;
                coef[s][1] <= 16'sd0;
                coef[s][2] <= 16'sd0;
                coef[s][3] <= 16'sd0;
                coef[s][4] <= 16'sd0;
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (coef_we && (coef_addr < NCOEF)) begin
                        for (int s = 0; s < SECTIONS; s++) begin
                            for (int i = 0; i < 5; i++) begin
                                if (coef_addr == 6'(s * 5 + i)) coef[s][i] <= coef_data;
                            end
                        end
                    end
                    if (clr_state) begin
                        for (int s = 0; s < NS; s++) begin
                            x1[s] <= '0;
                            x2[s] <= '0;
                            y1[s] <= '0;
                            y2[s] <= '0;
                        end
                    end
                    if (in_valid) begin
                        x_cur <= in_data;
                        sec   <= '0;
                        k     <= 3'd0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + {{3{prod[PW-1]}}, prod};
                    k   <= k + 3'd1;
                end
                UPDATE: begin
                    x2[sec]    <= x1[sec];
                    x1[sec]    <= x_cur;
                    y2[sec]    <= y1[sec];
                    y1[sec]    <= q;
                    x_cur      <= q;
                    acc        <= '0;
                    k          <= 3'd0;
                    sat_flag_r <= sat_flag_r | q_clip;
                    if (last_sec) begin
                        out_data_r  <= q;
                        out_valid_r <= 1'b1;
                    end else begin
                        sec <= sec + SW'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_biquad_cascade_seq.sv
// Scoreboard bench for biquad_cascade_seq (W=24, F=14, SECTIONS=2); the driver queues expected
// samples and a negedge monitor compares them against each out_valid strobe.
module tb_biquad_cascade_seq;
    localparam int W = 24;
`ifdef BIQUAD_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         coef_we = 1'b0;
    logic [5:0]   coef_addr = 6'd0;
    logic [15:0]  coef_data = 16'd0;
    logic         clr_state = 1'b0;
    logic         sat_flag;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int mon_exp;

    biquad_cascade_seq #(.W(W), .F(14), .SECTIONS(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .clr_state(clr_state), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got data %0d with no sample pending", $signed(out_data));
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", longint'($signed(out_data)), longint'(mon_exp));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: in_ready still 0 after %0d cycles", t);
        end
    endtask

    task automatic send(input int x, input int e, input bit push, input bit clr,
                        input bit we, input int a, input int d);
        wait_idle();
        in_valid  = 1'b1;
        in_data   = W'(x);
        clr_state = clr;
        coef_we   = we;
        coef_addr = 6'(a);
        coef_data = 16'(d);
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clr_state = 1'b0;
        coef_we   = 1'b0;
    endtask

    task automatic set_coef(input int a, input int d);
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = 6'(a);
        coef_data = 16'(d);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected samples never produced", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        clr_state = 1'b0;
        coef_we   = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
    endtask

    initial begin
        int lat;
        int busy;

        // Unity passthrough, latency and busy window
        do_reset();
        send(1000, 1000, 1'b1, 1'b0, 1'b0, 0, 0);
        lat  = -1;
        busy = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!in_ready) busy++;
            if (out_valid && lat < 0) lat = n;
            @(posedge clk);
        end
        check("latency", lat, 12);
        check("busy_cycles", busy, 13);
        drain();

        // FIR section: 0.5*(x + x1 + x2)
        do_reset();
        set_coef(0, 8192);
        set_coef(1, 8192);
        set_coef(2, 8192);
        send(16384, 8192, 1'b1, 1'b0, 1'b0, 0, 0);
        send(0, 8192, 1'b1, 1'b0, 1'b0, 0, 0);
        send(0, 8192, 1'b1, 1'b0, 1'b0, 0, 0);
        send(0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
        drain();

        // One-pole IIR y = x + 0.5*y1, then clear together with a new sample
        set_coef(0, 16384);
        set_coef(1, 0);
        set_coef(2, 0);
        set_coef(3, 8192);
        send(16384, 16384, 1'b1, 1'b1, 1'b0, 0, 0);
        send(0, 8192, 1'b1, 1'b0, 1'b0, 0, 0);
        send(0, 4096, 1'b1, 1'b0, 1'b0, 0, 0);
        send(0, 2048, 1'b1, 1'b0, 1'b0, 0, 0);
        send(0, 1024, 1'b1, 1'b0, 1'b0, 0, 0);
        send(0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
        drain();

        // Overflow: 8388607 * 32767 >>> 14 = 16776702 -> clamp or wrap to -514
        do_reset();
        set_coef(0, 32767);
        send(8388607, SAT_EN ? 8388607 : -514, 1'b1, 1'b0, 1'b0, 0, 0);
        drain();
        wait_idle();
        check("sat_flag", sat_flag, SAT_EN ? 1 : 0);

        // Reset during section-1 MAC abandons the sample
        do_reset();
        send(1000, 0, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (8) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (15) @(negedge clk);
        check("in_ready_after_abort", in_ready, 1);
        send(5, 5, 1'b1, 1'b0, 1'b0, 0, 0);
        drain();

        // Dropped writes (busy, out of range) and a write coincident with acceptance
        send(300, 300, 1'b1, 1'b0, 1'b0, 0, 0);
        coef_we   = 1'b1;
        coef_addr = 6'd0;
        coef_data = 16'd0;
        repeat (4) @(posedge clk);
        #1 coef_we = 1'b0;
        send(7, 7, 1'b1, 1'b0, 1'b0, 0, 0);
        set_coef(10, 0);
        send(9, 9, 1'b1, 1'b0, 1'b0, 0, 0);
        send(100, 50, 1'b1, 1'b0, 1'b1, 0, 8192);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
